uart_tx_scheduler: RTL

Shares the single RS-232 serial transmitter between two byte sources, requester A (processor I/O path) and requester B (debug/monitor path). It buffers one byte per requester and arbitrates round-robin. It drives the transmitter's data/start pins and sequences each frame by watching the transmitter's busy flag. It also reports per-requester completion and a start-timeout error.

---
 rtl/uart_tx_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one RS-232 transmitter between requesters A and B,
// buffering one byte each, arbitrating round-robin and timing out stalled starts.
module uart_tx_scheduler #(
  parameter int START_TIMEOUT = 2048,
  parameter int CW            = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  output logic       a_done,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       b_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       tx_owner,
  output logic       err_timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          full_a;
  logic          full_b;
  logic [7:0]    hold_a;
  logic [7:0]    hold_b;
  logic          last_owner;
  logic          accept_a;
  logic          accept_b;
  logic          grant_en;
  logic          grant_sel;

  assign a_ready  = ~full_a & ~rst;
  assign b_ready  = ~full_b & ~rst;
  assign accept_a = a_valid & a_ready;
  assign accept_b = b_valid & b_ready;

  // A tie goes to whoever did not own the previous frame; 0 selects A, 1 selects B.
  assign grant_en  = (state == ST_IDLE) & (full_a | full_b) & ~tx_busy;
  assign grant_sel = (full_a & full_b) ? ~last_owner : full_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_a <= 1'b0;
      hold_a <= 8'h00;
    end else if (accept_a) begin
      full_a <= 1'b1;
      hold_a <= a_data;
    end else if (grant_en && !grant_sel) begin
      full_a <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_b <= 1'b0;
      hold_b <= 8'h00;
    end else if (accept_b) begin
      full_b <= 1'b1;
      hold_b <= b_data;
    end else if (grant_en && grant_sel) begin
      full_b <= 1'b0;
    end
  end

  // tx_data is only loaded on a grant; the transmitter reads it bit by bit mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      last_owner  <= 1'b1;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      tx_owner    <= 1'b0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            tx_data    <= grant_sel ? hold_b : hold_a;
            tx_owner   <= grant_sel;
            last_owner <= grant_sel;
            cnt        <= '0;
            tx_start   <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= ST_WAIT;
          end else if (cnt == CNT_LAST) begin
            tx_start    <= 1'b0;
            err_timeout <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (!tx_busy) begin
            a_done <= ~tx_owner;
            b_done <= tx_owner;
            state  <= ST_IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
